// File: rtl/apb_sched_pkg.sv
// apb_sched_pkg: shared types and constants for the APB round-robin scheduler.
// Holds the FSM state encoding, the peripheral-select width and width helpers.
package apb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } sched_state_t;

    localparam int SEL_W = 3;

    // Width of the ACCESS wait counter; never narrower than one bit.
    function automatic int tmo_cnt_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 upward.
// Ports: eligible (request mask), ptr (last winner) -> grant (one-hot),
//        grant_idx (binary index of grant), any_grant (grant is non-zero).
module rr_arbiter
    import apb_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    always_comb begin
        int          c;
        logic [IW-1:0] ci;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        c         = 0;
        ci        = '0;
        // ptr < NREQ and k <= NREQ, so one subtraction wraps the index.
        for (int k = 1; k <= NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            ci = IW'(c);
            if (!any_grant && eligible[ci]) begin
                grant[ci] = 1'b1;
                grant_idx = ci;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_scheduler.sv
// apb_rr_scheduler: shares one APB master port between NREQ requesters with
// round-robin arbitration, sequencing SETUP/ACCESS and honouring Pready.
// Ports: Hclk, Hreset (sync, active-high); req/req_write/req_addr/req_wdata/
//        req_sel packed per requester; ack/rdata/err completion back to the
//        winner; Pselx/Penable/Pwrite/Paddr/Pwdata/Prdata/Pready APB master.
// Optional: define APB_TIMEOUT_EN to end stuck ACCESS phases with err=1.
module apb_rr_scheduler
    import apb_sched_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_wdata,
    input  logic [NREQ*SEL_W-1:0] req_sel,
    output logic [NREQ-1:0]       ack,
    output logic [DW-1:0]         rdata,
    output logic                  err,
    output logic [SEL_W-1:0]      Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [AW-1:0]         Paddr,
    output logic [DW-1:0]         Pwdata,
    input  logic [DW-1:0]         Prdata,
    input  logic                  Pready
);

    localparam int IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("apb_rr_scheduler: unsupported parameter value");
    end

    sched_state_t      state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     w_q, w_d;

    logic [SEL_W-1:0]  sel_d;
    logic              en_d;
    logic              wr_d;
    logic [AW-1:0]     addr_d;
    logic [DW-1:0]     wdata_d;
    logic [NREQ-1:0]   ack_d;
    logic [DW-1:0]     rdata_d;
    logic              err_d;
    logic              done;
    logic              tmo;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic              any_grant;

    logic              win_wr;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_wdata;
    logic [SEL_W-1:0]  win_sel;

`ifdef APB_TIMEOUT_EN
    localparam int            CW       = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    // A requester whose ack is visible may still hold req for its next
    // transfer; masking it here stops a double grant of the old request.
    assign eligible = req & ~ack;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_idx(gidx),
        .any_grant(any_grant)
    );

    // One-hot AND-OR mux of the winner's request fields.
    always_comb begin
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_wr    = win_wr | req_write[i];
                win_addr  = win_addr | req_addr[i*AW +: AW];
                win_wdata = win_wdata | req_wdata[i*DW +: DW];
                win_sel   = win_sel | req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        sel_d   = Pselx;
        en_d    = Penable;
        wr_d    = Pwrite;
        addr_d  = Paddr;
        wdata_d = Pwdata;
        ack_d   = '0;
        rdata_d = rdata;
        err_d   = err;
        done    = 1'b0;
        tmo     = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                en_d  = 1'b0;
                if (any_grant) begin
                    w_d     = gidx;
                    sel_d   = win_sel;
                    wr_d    = win_wr;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (Pready) done = 1'b1;
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) tmo = 1'b1;
                else cnt_d = cnt_q + 1'b1;
`endif
                if (done || tmo) begin
                    sel_d      = '0;
                    en_d       = 1'b0;
                    ack_d[w_q] = 1'b1;
                    err_d      = tmo;
                    if (tmo) rdata_d = '0;
                    else if (!Pwrite) rdata_d = Prdata;
                    ptr_d      = w_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            w_q     <= '0;
            Pselx   <= '0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= '0;
            Pwdata  <= '0;
            ack     <= '0;
            rdata   <= '0;
            err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            Pselx   <= sel_d;
            Penable <= en_d;
            Pwrite  <= wr_d;
            Paddr   <= addr_d;
            Pwdata  <= wdata_d;
            ack     <= ack_d;
            rdata   <= rdata_d;
            err     <= err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// tb_apb_rr_scheduler: randomized and directed stimulus for apb_rr_scheduler,
// checked every cycle against a transfer-level reference model.
module tb_apb_rr_scheduler;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic              Hclk = 1'b0;
    logic              Hreset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*3-1:0] req_sel;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [AW-1:0]     Paddr;
    logic [DW-1:0]     Pwdata;
    logic [DW-1:0]     Prdata;
    logic              Pready;

    apb_rr_scheduler #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Hclk(Hclk), .Hreset(Hreset),
        .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .ack(ack), .rdata(rdata), .err(err),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready)
    );

    always #5 Hclk = ~Hclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one in-flight transfer with an age in cycles
    // since grant (1 = setup, >=2 = access).
    int              m_ptr;
    bit              m_busy;
    int              m_w;
    int              m_age;
    logic [NREQ-1:0] m_ack;
    logic [DW-1:0]   m_rdata;
    bit              m_err;
    logic [2:0]      m_sel;
    bit              m_write;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;

    int dut_wins[$];

    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int w;
        bit to;
        if (Hreset) begin
            m_busy = 0; m_ptr = NREQ - 1; m_ack = '0; m_rdata = '0;
            m_err = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_sel = '0;
            return;
        end
        elig  = req & ~m_ack;
        m_ack = '0;
        if (!m_busy) begin
            if (elig != 0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_busy  = 1; m_w = w; m_age = 1;
                m_sel   = req_sel[w*3 +: 3];
                m_write = req_write[w];
                m_addr  = req_addr[w*AW +: AW];
                m_wdata = req_wdata[w*DW +: DW];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            to = 0;
`ifdef APB_TIMEOUT_EN
            to = !Pready && (m_age - 2 == TMO - 1);
`endif
            if (Pready || to) begin
                m_ack[m_w] = 1'b1;
                m_err      = to;
                if (to) m_rdata = '0;
                else if (!m_write) m_rdata = Prdata;
                m_ptr  = m_w;
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ack", ack, m_ack);
        chk("ack_onehot", $onehot0(ack), 1);
        chk("rdata", rdata, m_rdata);
        chk("err", err, m_err);
        chk("pselx", Pselx, m_busy ? m_sel : 3'b000);
        chk("penable", Penable, m_busy && m_age >= 2);
        chk("pwrite", Pwrite, m_write);
        chk("paddr", Paddr, m_addr);
        chk("pwdata", Pwdata, m_wdata);
    endtask

    task automatic step();
        @(posedge Hclk);
        model_edge();
        @(negedge Hclk);
        check_outputs();
        if (ack != 0) dut_wins.push_back(onehot_idx(ack));
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] s);
        req[i]                = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_sel[i*3 +: 3]     = s;
    endtask

    task automatic new_fields(input int i);
        logic [2:0] s;
        if ($urandom_range(9) == 0) s = 3'($urandom);
        else s = 3'(1 << $urandom_range(2));
        set_req(i, 1'($urandom), $urandom, $urandom, s);
    endtask

    task automatic drive_rand(input int p_req, input int keep, input int p_rdy,
                              input logic [NREQ-1:0] en);
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (m_ack[i]) begin
                    if (en[i] && $urandom_range(99) < keep) new_fields(i);
                    else req[i] = 1'b0;
                end
            end else if (en[i] && $urandom_range(99) < p_req) begin
                new_fields(i);
            end
        end
        Pready = ($urandom_range(99) < p_rdy);
        Prdata = $urandom;
    endtask

    task automatic wait_ack(input int i, input string tag);
        int n;
        n = 0;
        while (n < 40 && !ack[i]) begin step(); n++; end
        chk(tag, ack[i], 1);
    endtask

    initial begin
        int n;
        int n_acc;
        int extra;
        bit got;
        Hreset = 1'b1; req = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_sel = '0; Prdata = '0; Pready = 1'b0;
        repeat (3) step();
        Hreset = 1'b0;
        step();

        // Single read latency.
        set_req(0, 0, 32'h1000, 32'h0, 3'b001);
        Pready = 1'b1; Prdata = 32'hCAFE0001;
        n = 0;
        while (n < 20) begin step(); n++; if (ack[0]) break; end
        chk("rd_lat", n, 3);
        chk("rd_data", rdata, 32'hCAFE0001);
        req[0] = 1'b0;
        repeat (2) step();

        // Contention after reset: grants alternate 0,1,0,1.
        Hreset = 1'b1; step(); Hreset = 1'b0;
        new_fields(0); new_fields(1); Pready = 1'b1;
        dut_wins.delete();
        repeat (13) begin step(); drive_rand(100, 100, 100, 3'b011); end
        chk("cont_n", dut_wins.size(), 4);
        for (int k = 0; k < 4 && k < dut_wins.size(); k++)
            chk("cont_order", dut_wins[k], k % 2);
        repeat (10) begin step(); drive_rand(0, 0, 100, 3'b000); end

        // Write with four wait states.
        set_req(2, 1, 32'hA5A5_0040, 32'h1234_5678, 3'b100);
        Pready = 1'b0; n_acc = 0; got = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ack[2]) begin got = 1; break; end
            if (Penable) n_acc++;
            Pready = (n_acc >= 5);
        end
        chk("ws_ack", got, 1);
        chk("ws_access", n_acc, 5);
        req[2] = 1'b0; extra = 0;
        repeat (4) begin step(); if (ack != 0) extra++; end
        chk("ws_once", extra, 0);

        // Reset in the middle of ACCESS.
        set_req(0, 0, 32'h2000, 32'h0, 3'b001);
        set_req(1, 1, 32'h3000, 32'h77, 3'b010);
        Pready = 1'b0; n = 0;
        while (n < 10 && !Penable) begin step(); n++; end
        repeat (2) step();
        Hreset = 1'b1; step();
        chk("rst_pen", Penable, 0);
        chk("rst_psel", Pselx, 0);
        chk("rst_ack", ack, 0);
        Hreset = 1'b0; Pready = 1'b1; n = 0;
        while (n < 20) begin step(); n++; if (ack != 0) break; end
        chk("rst_first", ack, 3'b001);
        req[0] = 1'b0;
        wait_ack(1, "rst_second");
        req[1] = 1'b0;
        repeat (2) step();

        // Slave stuck with Pready low.
        set_req(1, 0, 32'h4000, 32'h0, 3'b010);
        Pready = 1'b0; Prdata = 32'h5555_AAAA; n_acc = 0; got = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (ack != 0) begin got = 1; break; end
            if (Penable) n_acc++;
            if (Penable && !req[0]) set_req(0, 1, 32'h5000, 32'h99, 3'b001);
        end
`ifdef APB_TIMEOUT_EN
        chk("tmo_ack", ack, 3'b010);
        chk("tmo_err", err, 1);
        chk("tmo_rdata", rdata, 0);
        chk("tmo_len", n_acc, TMO);
        req[1] = 1'b0; Pready = 1'b1;
        wait_ack(0, "tmo_next");
        chk("tmo_next_err", err, 0);
        req[0] = 1'b0;
`else
        chk("stuck_noack", got, 0);
        chk("stuck_pen", Penable, 1);
        chk("stuck_psel", Pselx, 3'b010);
        Pready = 1'b1;
        wait_ack(1, "stuck_done");
        req[1] = 1'b0;
        wait_ack(0, "stuck_next");
        req[0] = 1'b0;
`endif
        repeat (2) step();

        // Re-grant mask: requester 1 alone, keeping req high across acks.
        repeat (20) begin step(); drive_rand(100, 100, 70, 3'b010); end
        repeat (10) begin step(); drive_rand(0, 0, 100, 3'b000); end

        // Random traffic with occasional resets.
        repeat (2500) begin
            step();
            Hreset = ($urandom_range(399) == 0);
            drive_rand(40, 50, 60, '1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
